booth_controller: RTL and testbench
===================================

Name: booth_controller

Overview:
- Sequencer and register file for the radix-2 Booth signed multiplier.
- Drives the add/sub/init control interface of the multiplier's combinational adder and owns the A, Q, Q-1, M registers and the iteration counter.
- Feeds the adder operands, captures the adder result, performs the arithmetic right shifts, and presents a 2W-bit signed product with a done pulse.

Parameters:
- REG_WIDTH, 8, operand width W in bits. Legal range 2..32. Product width is 2W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiplication; sampled only in IDLE.
- multiplicand  in  W  signed two's-complement M; latched on accepted start.
- multiplier  in  W  signed two's-complement Q; latched on accepted start.
- ctl_add  out  1  adder control bit.
- ctl_sub  out  1  adder control bit.
- ctl_init  out  1  adder control bit.
- adder_a  out  W  adder operand A; always equals the A register.
- adder_b  out  W  adder operand B; always equals the M register.
- adder_c  in  W  adder result; combinational from adder_a/adder_b/controls.
- busy  out  1  high from the cycle after start is accepted through the DONE state.
- done  out  1  one-cycle pulse; product valid.
- product  out  2W  {A,Q} after the final shift; held until the next accepted start or reset.
- range_err  out  1  valid with done; 1 if the latched M == -2^(W-1).

Behaviour:
- Adder control encoding {ctl_add,ctl_sub,ctl_init}:
  - 3'b100 = A+M.
  - 3'b110 = A-M (ctl_add is also high for subtract).
  - 3'b001 = clear.
  - 3'b000 = adder idle.
  - No other code is ever driven.
- Controls are a combinational decode of registered state, Q[0] and Q-1 only; no glitching from inputs.
- Reset (rst=1 at an edge): go to IDLE; A, Q, M, Q-1, count, product, range_err all 0; done=0, busy=0; controls 000.
- Reset mid-operation: abort immediately with the same values; no done pulse.
- IDLE: controls 000.
  - On start=1: latch M, Q; Q-1<=0; count<=W; range_err<=(multiplicand==-2^(W-1)); go to INIT.
- INIT (1 cycle): controls 001; A<=adder_c (zero); go to ARITH.
- ARITH (1 cycle):
  - {Q[0],Q-1}=10: controls 110; A<=adder_c.
  - {Q[0],Q-1}=01: controls 100; A<=adder_c.
  - 00 or 11: controls 000; A unchanged.
  - Next state: SHIFT.
- SHIFT (1 cycle): controls 000.
  - Arithmetic right shift of {A,Q,Q-1}: A[W-1] replicated, A[0]->Q[W-1], Q[0]->Q-1.
  - count<=count-1.
  - If count==1 before decrement, go to DONE; else go to ARITH.
- DONE (1 cycle): done=1; product<={A,Q}; go to IDLE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+2W+1, i.e. 2W+2 cycles (18 for W=8). Throughput: one product per 2W+3 cycles (back-to-back start sampled in IDLE only).
- start while busy: ignored, with no effect on latched operands. start held high continuously: restarts from the IDLE cycle after DONE.
- Arithmetic:
  - A wraps modulo 2^W, with no sign extension of adder_c beyond W.
  - product is correct two's-complement for every operand pair except M=-2^(W-1), where range_err=1 and product is the raw algorithm result (not checked).
  - A multiplier of -2^(W-1) is legal.
- adder_a and adder_b are valid in every state. The adder result is only captured in INIT and in ARITH with a non-idle code.

Test Plan:
- W=8, M=3, Q=5 -> ARITH codes per iteration: 110,100,110,100,000,000,000,000; done 18 cycles after start; product=16'h000F; range_err=0.
- M=-3 (8'hFD), Q=5 -> product=16'hFFF1 (-15). M=7, Q=-128 (8'h80) -> product=16'hFC80 (-896). M=-1, Q=-1 -> 16'h0001.
- M=0, Q=8'h5A and M=8'h5A, Q=0 -> product=16'h0000. For Q=0, every ARITH code is 000 and A never changes.
- M=-128, Q=1 -> done pulses with range_err=1.
- start pulsed again at cycle 5 of a 3*5 operation with M=9, Q=9 -> ignored; product 16'h000F. Then a new start gives 16'h0051.
- rst=1 at cycle 7 of an operation -> next cycle all outputs 0, state IDLE, no done. A following 2*3 yields 16'h0006.

Source files
------------

// File: rtl/booth_controller_if.sv
// Control and data bundle between the Booth sequencer, its requester and the external adder.
interface booth_controller_if #(
    parameter int unsigned REG_WIDTH = 8
);
    logic                   start;
    logic [REG_WIDTH-1:0]   multiplicand;
    logic [REG_WIDTH-1:0]   multiplier;
    logic                   ctl_add;
    logic                   ctl_sub;
    logic                   ctl_init;
    logic [REG_WIDTH-1:0]   adder_a;
    logic [REG_WIDTH-1:0]   adder_b;
    logic [REG_WIDTH-1:0]   adder_c;
    logic                   busy;
    logic                   done;
    logic [2*REG_WIDTH-1:0] product;
    logic                   range_err;

    // Environment side: requester plus the combinational adder.
    modport master (
        output start, multiplicand, multiplier, adder_c,
        input  ctl_add, ctl_sub, ctl_init, adder_a, adder_b, busy, done, product, range_err
    );

    // Sequencer side.
    modport slave (
        input  start, multiplicand, multiplier, adder_c,
        output ctl_add, ctl_sub, ctl_init, adder_a, adder_b, busy, done, product, range_err
    );
endinterface

// File: rtl/booth_controller.sv
// Radix-2 Booth multiplier sequencer: owns A, Q, Q-1, M and the iteration count,
// drives the external adder controls and presents a 2W-bit signed product with a done pulse.
module booth_controller #(
    parameter int unsigned REG_WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    booth_controller_if.slave bus
);
    localparam int unsigned CntW = $clog2(REG_WIDTH + 1);
    localparam logic [REG_WIDTH-1:0] MinNeg = {1'b1, {(REG_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StInit, StArith, StShift, StDone} state_e;

    state_e                 state_q, state_d;
    logic [REG_WIDTH-1:0]   a_q, a_d;
    logic [REG_WIDTH-1:0]   q_q, q_d;
    logic [REG_WIDTH-1:0]   m_q, m_d;
    logic                   qm1_q, qm1_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [2*REG_WIDTH-1:0] prod_q, prod_d;
    logic                   rerr_q, rerr_d;
    logic                   ctl_add, ctl_sub, ctl_init, done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            rerr_q  <= rerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        m_d      = m_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        rerr_d   = rerr_q;
        ctl_add  = 1'b0;
        ctl_sub  = 1'b0;
        ctl_init = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    m_d     = bus.multiplicand;
                    q_d     = bus.multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = CntW'(REG_WIDTH);
                    rerr_d  = (bus.multiplicand == MinNeg);
                    state_d = StInit;
                end
            end
            StInit: begin
                ctl_init = 1'b1;
                a_d      = bus.adder_c;
                state_d  = StArith;
            end
            StArith: begin
                // Booth recoding of the current bit pair: 10 subtracts M, 01 adds M.
                case ({q_q[0], qm1_q})
                    2'b10: begin
                        ctl_add = 1'b1;
                        ctl_sub = 1'b1;
                        a_d     = bus.adder_c;
                    end
                    2'b01: begin
                        ctl_add = 1'b1;
                        a_d     = bus.adder_c;
                    end
                    default: ;
                endcase
                state_d = StShift;
            end
            StShift: begin
                {a_d, q_d, qm1_d} = {a_q[REG_WIDTH-1], a_q, q_q};
                cnt_d             = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    // Capture on entry to DONE so the product is valid alongside the pulse.
                    prod_d  = {a_d, q_d};
                    state_d = StDone;
                end else begin
                    state_d = StArith;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.ctl_add   = ctl_add;
    assign bus.ctl_sub   = ctl_sub;
    assign bus.ctl_init  = ctl_init;
    assign bus.adder_a   = a_q;
    assign bus.adder_b   = m_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done;
    assign bus.product   = prod_q;
    assign bus.range_err = rerr_q;
endmodule

// File: tb/tb_booth_controller.sv
// Randomised and directed bench for booth_controller against a signed-arithmetic reference model.
module tb_booth_controller;
    localparam int W  = 8;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    booth_controller_if #(.REG_WIDTH(W)) bus();

    booth_controller #(.REG_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] code;
    assign code = {bus.ctl_add, bus.ctl_sub, bus.ctl_init};

    // Behavioural adder; idle code still produces a sum so stray captures are visible.
    always_comb begin
        case (code)
            3'b110:  bus.adder_c = bus.adder_a - bus.adder_b;
            3'b001:  bus.adder_c = '0;
            default: bus.adder_c = bus.adder_a + bus.adder_b;
        endcase
    end

    always @(negedge clk) begin
        total++;
        if (!(code inside {3'b000, 3'b100, 3'b110, 3'b001})) begin
            bad++;
            $display("FAIL ctl_code got=%b want one of 000/100/110/001", code);
        end
    end

    int         lat;
    logic [2:0] codes [W];
    logic [2:0] init_code;
    logic       busy_ok, a_moved, got_done;

    function automatic logic [PW-1:0] model_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        int pm, pq;
        pm = int'($signed(m));
        pq = int'($signed(q));
        return PW'(pm * pq);
    endfunction

    // Booth rule on the original multiplier bits: pair (q[i], q[i-1]) with q[-1] = 0.
    function automatic logic [2:0] model_code(input logic [W-1:0] q, input int i);
        logic cur, prev;
        cur  = q[i];
        prev = (i == 0) ? 1'b0 : q[i-1];
        if (cur && !prev) return 3'b110;
        if (!cur && prev) return 3'b100;
        return 3'b000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q);
        bus.multiplicand = m;
        bus.multiplier   = q;
        bus.start        = 1'b1;
        tick();
        bus.start = 1'b0;
        lat       = 1;
        init_code = code;
        busy_ok   = bus.busy;
        a_moved   = 1'b0;
        got_done  = 1'b0;
    endtask

    task automatic wait_done();
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
            if (lat % 2 == 0 && lat <= 2 * W) codes[lat/2-1] = code;
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.adder_a != '0) a_moved = 1'b1;
        end
        got_done = bus.done;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        tick();
        tick();
        rst = 1'b0;
        total += 7;
        if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        if (bus.done !== 1'b0)      begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        if (bus.product !== '0)     begin bad++; $display("FAIL rst_product got=%h want=0", bus.product); end
        if (bus.range_err !== 1'b0) begin bad++; $display("FAIL rst_range_err got=%b want=0", bus.range_err); end
        if (code !== 3'b000)        begin bad++; $display("FAIL rst_ctl got=%b want=000", code); end
        if (bus.adder_a !== '0)     begin bad++; $display("FAIL rst_adder_a got=%h want=0", bus.adder_a); end
        if (bus.adder_b !== '0)     begin bad++; $display("FAIL rst_adder_b got=%h want=0", bus.adder_b); end
        tick();
    endtask

    task automatic test_products(input int n_rand);
        logic [W-1:0] ms [$] = '{8'h03, 8'hFD, 8'h07, 8'hFF, 8'h00, 8'h5A, 8'h80};
        logic [W-1:0] qs [$] = '{8'h05, 8'h05, 8'h80, 8'hFF, 8'h5A, 8'h00, 8'h01};
        logic [PW-1:0] held;
        logic          codes_ok;
        for (int i = 0; i < n_rand; i++) begin
            ms.push_back(W'($urandom));
            qs.push_back(($urandom_range(0, 7) == 0) ? 8'h80 : W'($urandom));
        end
        for (int i = 0; i < ms.size(); i++) begin
            start_op(ms[i], qs[i]);
            wait_done();
            codes_ok = 1'b1;
            for (int b = 0; b < W; b++) if (codes[b] !== model_code(qs[i], b)) codes_ok = 1'b0;
            total += 5;
            if (got_done !== 1'b1) begin bad++; $display("FAIL op%0d_done got=%b want=1", i, got_done); end
            if (lat != 2 * W + 2)  begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, 2 * W + 2); end
            if (init_code !== 3'b001) begin bad++; $display("FAIL op%0d_init_ctl got=%b want=001", i, init_code); end
            if (!codes_ok || !busy_ok) begin
                bad++;
                $display("FAIL op%0d_arith_codes got codes_ok=%b busy_ok=%b want 1/1", i, codes_ok, busy_ok);
            end
            if (bus.range_err !== (ms[i] == 8'h80)) begin
                bad++;
                $display("FAIL op%0d_range_err got=%b want=%b", i, bus.range_err, ms[i] == 8'h80);
            end
            if (ms[i] != 8'h80) begin
                total++;
                if (bus.product !== model_prod(ms[i], qs[i])) begin
                    bad++;
                    $display("FAIL op%0d_product m=%h q=%h got=%h want=%h", i, ms[i], qs[i],
                             bus.product, model_prod(ms[i], qs[i]));
                end
            end
            if (qs[i] == '0) begin
                total++;
                if (a_moved !== 1'b0) begin bad++; $display("FAIL op%0d_a_static got=%b want=0", i, a_moved); end
            end
            held = bus.product;
            tick();
            tick();
            total++;
            if (bus.product !== held || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL op%0d_hold got=%h/%b want=%h/0", i, bus.product, bus.done, held);
            end
        end
    endtask

    task automatic test_busy_start();
        start_op(8'd3, 8'd5);
        while (lat < 5) begin tick(); lat++; end
        bus.multiplicand = 8'd9;
        bus.multiplier   = 8'd9;
        bus.start        = 1'b1;
        tick();
        lat++;
        bus.start = 1'b0;
        wait_done();
        total += 2;
        if (got_done !== 1'b1 || lat != 2 * W + 2) begin
            bad++;
            $display("FAIL busy_start_latency got=%0d done=%b want=%0d", lat, got_done, 2 * W + 2);
        end
        if (bus.product !== 16'h000F) begin bad++; $display("FAIL busy_start_product got=%h want=000f", bus.product); end
        tick();
        start_op(8'd9, 8'd9);
        wait_done();
        total++;
        if (bus.product !== 16'h0051) begin bad++; $display("FAIL restart_product got=%h want=0051", bus.product); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        start_op(8'h80, 8'd3);
        while (lat < 7) begin tick(); lat++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 4;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_flags got busy=%b done=%b want 0/0", bus.busy, bus.done);
        end
        if (bus.product !== '0 || bus.range_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_result got=%h/%b want=0000/0", bus.product, bus.range_err);
        end
        if (bus.adder_a !== '0 || bus.adder_b !== '0) begin
            bad++;
            $display("FAIL mid_rst_regs got a=%h b=%h want 0/0", bus.adder_a, bus.adder_b);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 2 * W + 4; c++) begin
            tick();
            if (bus.done || bus.busy) saw_done = 1'b1;
        end
        if (saw_done !== 1'b0) begin bad++; $display("FAIL mid_rst_quiet got=%b want=0", saw_done); end
        start_op(8'd2, 8'd3);
        wait_done();
        total++;
        if (bus.product !== 16'h0006) begin bad++; $display("FAIL post_rst_product got=%h want=0006", bus.product); end
        tick();
    endtask

    task automatic test_back_to_back();
        int gap;
        bus.multiplicand = 8'h0B;
        bus.multiplier   = 8'hF3;
        bus.start        = 1'b1;
        tick();
        lat     = 1;
        busy_ok = bus.busy;
        wait_done();
        total += 2;
        if (bus.product !== model_prod(8'h0B, 8'hF3)) begin
            bad++;
            $display("FAIL b2b_first got=%h want=%h", bus.product, model_prod(8'h0B, 8'hF3));
        end
        gap = 0;
        do begin
            tick();
            gap++;
        end while (!bus.done && gap < 100);
        if (gap != 2 * W + 3 || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=%0d", gap, 2 * W + 3);
        end
        total++;
        if (bus.product !== 16'hFF71) begin bad++; $display("FAIL b2b_second got=%h want=ff71", bus.product); end
        bus.start = 1'b0;
        tick();
        tick();
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b want=0", bus.busy); end
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        test_reset();
        test_products(40);
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
